// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } frame_state_t;

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: MAX_LEN x 8 register file, synchronous write, asynchronous read.
// Latency: write visible the cycle after wr_en; read is combinational.
// Backpressure: none; the owner sequences writes and reads.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: SOF hunt, length and checksum check, payload release.
// Latency: status pulses and first payload byte one cycle after the CSUM strobe; one byte/cycle drain.
// Backpressure: m_ready stalls the drain with data held; strobes during drain are dropped (overrun). Option: UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF          = DEFAULT_SOF,
    parameter int         TIMEOUT_CLKS = 260420
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_line,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t  state;
    logic [7:0]    len;
    logic [7:0]    csum;
    logic [7:0]    csum_fin;
    logic [7:0]    wr_idx;
    logic [7:0]    rd_idx;
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic          tmo_hit;

    assign csum_fin = csum + rx_line;
    assign wr_en    = (state == ST_PAYLOAD) && rx_done;
    // Read port looks one byte ahead so m_data can be registered on each accept.
    assign rd_addr  = (state == ST_DRAIN) ? AW'(rd_idx + 8'd1) : '0;

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_idx[AW-1:0]),
        .wr_data (rx_line),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_frame;

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    assign tmo_hit  = in_frame && !rx_done && (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (rx_done || !in_frame || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CLKS;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HUNT;
            len       <= '0;
            csum      <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            overrun   <= 1'b0;
            if (tmo_hit) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_HUNT;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (rx_done && rx_line == SOF) begin
                            state <= ST_LEN;
                            busy  <= 1'b1;
                        end
                    end
                    ST_LEN: begin
                        if (rx_done) begin
                            if (rx_line == 8'd0 || rx_line > MAX_LEN_B) begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_LEN;
                                state     <= ST_HUNT;
                                busy      <= 1'b0;
                            end else begin
                                len    <= rx_line;
                                csum   <= rx_line;
                                wr_idx <= '0;
                                state  <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_done) begin
                            csum   <= csum_fin;
                            wr_idx <= wr_idx + 8'd1;
                            if (wr_idx == len - 8'd1) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_done) begin
                            if (csum_fin == 8'd0) begin
                                frame_ok <= 1'b1;
                                m_valid  <= 1'b1;
                                m_data   <= rd_data;
                                m_last   <= (len == 8'd1);
                                rd_idx   <= '0;
                                state    <= ST_DRAIN;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_CSUM;
                                state     <= ST_HUNT;
                                busy      <= 1'b0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (rx_done) begin
                            overrun <= 1'b1;
                        end
                        if (m_ready) begin
                            if (m_last) begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                                m_data  <= '0;
                                state   <= ST_HUNT;
                                busy    <= 1'b0;
                            end else begin
                                rd_idx <= rd_idx + 8'd1;
                                m_data <= rd_data;
                                m_last <= (rd_idx + 8'd1 == len - 8'd1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frames built from the format rules, responses checked by a monitor.
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] SOF_B   = 8'hA5;
    localparam int         MAXL    = 16;
    localparam int         TMO     = 200;
    localparam int         K_GOOD  = 0;
    localparam int         K_BADCS = 1;
    localparam int         K_BADLEN = 2;
    localparam int         EV_OK   = 0;
    localparam int         EV_OVR  = 4;

    logic       clk;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_line;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;
    logic       busy;

    int         checks;
    int         errors;
    int         m_mode;
    int         got;
    int         exp_evt [$];
    logic [8:0] exp_byte [$];
    logic [7:0] pay [$];

    uart_rx_frame_ctrl #(
        .MAX_LEN      (MAXL),
        .SOF          (SOF_B),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_done   (rx_done),
        .rx_line   (rx_line),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_data"}, 32'(m_data), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_last"}, 32'(m_last), 0);
        chk({tag, "_frame_ok"}, 32'(frame_ok), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Monitor: pulses are matched against the event queue, bytes against the byte queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (frame_ok || frame_err || overrun) begin
                got = frame_ok ? EV_OK : (frame_err ? int'(err_code) : EV_OVR);
                if (exp_evt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_unexpected actual=%0d required=none t=%0t", got, $time);
                end else begin
                    chk("evt", 32'(got), 32'(exp_evt.pop_front()));
                end
                chk("pulse_onehot", 32'($countones({frame_ok, frame_err, overrun})), 1);
                if (frame_ok) chk("valid_with_ok", 32'(m_valid), 1);
            end
            if (!frame_err) chk("err_code_idle", 32'(err_code), 0);
            if (m_valid) begin
                if (exp_byte.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected actual=%0h required=none t=%0t", {m_last, m_data}, $time);
                end else begin
                    chk("byte", 32'({m_last, m_data}), 32'(exp_byte[0]));
                    if (m_ready) void'(exp_byte.pop_front());
                end
            end
        end
    end

    // m_ready pattern: 0 always high, 1 = 1,0,0 repeating, 2 random, else low.
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (m_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_done = 1'b1;
        rx_line = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_line = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_evt.size() != 0 || exp_byte.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL idle_wait actual=%0d/%0d pending required=0/0", exp_evt.size(), exp_byte.size());
            exp_evt.delete();
            exp_byte.delete();
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid", 32'(m_valid), 0);
    endtask

    // Builds one frame from the format rules; pay may be preloaded, else it is randomised.
    task automatic run_frame(input int kind, input logic [7:0] len_b, input int n_garb, input bit ovr);
        logic [7:0] sum;
        logic [7:0] g;
        for (int i = 0; i < n_garb; i++) begin
            g = 8'($urandom);
            if (g == SOF_B) g = 8'h00;
            send_byte(g, $urandom_range(0, 3));
        end
        send_byte(SOF_B, $urandom_range(0, 3));
        if (kind == K_BADLEN) begin
            exp_evt.push_back(2);
            send_byte(len_b, 0);
        end else begin
            if (pay.size() == 0) begin
                for (int i = 0; i < int'(len_b); i++) pay.push_back(8'($urandom));
            end
            sum = len_b;
            foreach (pay[i]) sum = sum + pay[i];
            send_byte(len_b, $urandom_range(0, 3));
            foreach (pay[i]) send_byte(pay[i], $urandom_range(0, 3));
            if (kind == K_GOOD) begin
                exp_evt.push_back(EV_OK);
                foreach (pay[i]) exp_byte.push_back({i == int'(len_b) - 1, pay[i]});
                if (ovr) exp_evt.push_back(EV_OVR);
                send_byte(8'(0 - sum), 0);
                if (ovr) send_byte(8'($urandom), 0);
            end else begin
                exp_evt.push_back(1);
                send_byte(8'(0 - sum) + 8'($urandom_range(1, 255)), 0);
            end
        end
        pay.delete();
        wait_idle();
    endtask

    initial begin
        int kind;
        logic [7:0] lb;
        checks  = 0;
        errors  = 0;
        m_mode  = 0;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_line = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("rst_held");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_zero("rst_exit");

        // Directed: good frame, same frame with bad checksum, then good again.
        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(K_GOOD, 8'd3, 0, 1'b0);
        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(K_BADCS, 8'd3, 0, 1'b0);
        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(K_GOOD, 8'd3, 0, 1'b0);

        // Length boundaries: 0, MAX_LEN+1 rejected; 1 and MAX_LEN accepted.
        run_frame(K_BADLEN, 8'd0, 0, 1'b0);
        run_frame(K_BADLEN, 8'd17, 0, 1'b0);
        run_frame(K_GOOD, 8'd1, 0, 1'b0);
        run_frame(K_GOOD, 8'd16, 0, 1'b0);

        // Stalled drain with a strobe injected during DRAIN.
        m_mode = 1;
        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(K_GOOD, 8'd3, 0, 1'b1);
        m_mode = 0;

        // Garbage ahead of the SOF is ignored silently.
        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 2);
        pay = '{8'h01, 8'h02};
        run_frame(K_GOOD, 8'd2, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            m_mode = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            if (kind >= 8) begin
                lb = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
                run_frame(K_BADLEN, lb, $urandom_range(0, 2), 1'b0);
            end else begin
                run_frame((kind >= 6) ? K_BADCS : K_GOOD, 8'($urandom_range(1, MAXL)),
                          $urandom_range(0, 2), $urandom_range(0, 3) == 0);
            end
        end
        m_mode = 0;

`ifdef UART_RX_FRAME_TIMEOUT_EN
        send_byte(SOF_B, 0);
        send_byte(8'h03, 0);
        exp_evt.push_back(3);
        send_byte(8'h11, 0);
        wait_idle();
`endif

        // Reset during a stalled drain clears everything at once.
        m_mode = 3;
        @(posedge clk);
        #1;
        exp_evt.push_back(EV_OK);
        exp_byte.push_back({1'b0, 8'h11});
        send_byte(SOF_B, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h97, 2);
        chk("stall_valid", 32'(m_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_async");
        exp_evt.delete();
        exp_byte.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_mode = 0;
        @(posedge clk);
        #1;
        chk_outputs_zero("rst_after");
        pay = '{8'h01, 8'h02};
        run_frame(K_GOOD, 8'd2, 0, 1'b0);

        chk("final_evt_q", 32'(exp_evt.size()), 0);
        chk("final_byte_q", 32'(exp_byte.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
